// File: rtl/serial_bus_rx_if.sv
// Serial link receive interface: serial input, parallel valid/ready output and sticky status.
// PARITY_CHECK_EN adds the parity_err status bit.
interface serial_bus_rx_if #(parameter int WIDTH = 2);
  logic             sdata;
  logic             sframe;
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;
  logic             bus_ready;
  logic             overrun;
  logic             frame_err;
  logic             clr_err;
`ifdef PARITY_CHECK_EN
  logic             parity_err;
`endif

  modport master (
    output sdata, sframe, bus_ready, clr_err,
    input  bus_out, bus_valid, overrun,
`ifdef PARITY_CHECK_EN
    input  parity_err,
`endif
    input  frame_err
  );

  modport slave (
    input  sdata, sframe, bus_ready, clr_err,
    output bus_out, bus_valid, overrun,
`ifdef PARITY_CHECK_EN
    output parity_err,
`endif
    output frame_err
  );
endinterface

// File: rtl/serial_bus_rx.sv
// Two-wire serial receiver: reassembles LSB-first frames into WIDTH-bit words.
// Optional macro PARITY_CHECK_EN: trailing even-parity bit per frame, checked before delivery.
//   state  | meaning
//   IDLE   | waiting for sframe
//   SHIFT  | collecting data bits 1..WIDTH-1
//   PARITY | sampling the parity bit (PARITY_CHECK_EN only)
module serial_bus_rx #(
  parameter int WIDTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  serial_bus_rx_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;

  logic [WIDTH-1:0] shift_in, first_in, word;
  logic             done, ovr_set, ferr_set, perr_set;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    done        = 1'b0;
    ovr_set     = 1'b0;
    ferr_set    = 1'b0;
    perr_set    = 1'b0;
    word        = shift_q;
    // Bits enter at the MSB and move down, so bit 0 lands at index 0 after WIDTH shifts.
    shift_in            = shift_q >> 1;
    shift_in[WIDTH-1]   = bus.sdata;
    first_in            = '0;
    first_in[WIDTH-1]   = bus.sdata;

    if (bus.sframe) begin
      ferr_set = (state_q != IDLE);
      shift_d  = first_in;
      if (WIDTH == 1) begin
        count_d = '0;
`ifdef PARITY_CHECK_EN
        state_d = PARITY;
`else
        state_d = IDLE;
        done    = 1'b1;
        word    = first_in;
`endif
      end else begin
        count_d = CW'(1);
        state_d = SHIFT;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          shift_d = shift_in;
          if (count_q == LAST) begin
            count_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done    = 1'b1;
            word    = shift_in;
`endif
          end else begin
            count_d = count_q + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          state_d = IDLE;
          if (^{shift_q, bus.sdata}) begin
            perr_set = 1'b1;
          end else begin
            done = 1'b1;
            word = shift_q;
          end
        end
`endif
        default: ;
      endcase
    end

    if (done) begin
      if (!bus_valid_q || bus.bus_ready) begin
        bus_out_d   = word;
        bus_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (bus_valid_q && bus.bus_ready) begin
      bus_valid_d = 1'b0;
    end

    // A new error event outranks a simultaneous clear.
    overrun_d    = ovr_set  | (overrun_q    & ~bus.clr_err);
    frame_err_d  = ferr_set | (frame_err_q  & ~bus.clr_err);
    parity_err_d = perr_set | (parity_err_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      bus_out_q    <= '0;
      bus_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      bus_out_q    <= bus_out_d;
      bus_valid_q  <= bus_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.bus_out   = bus_out_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_bus_rx.sv
// Bench for serial_bus_rx: WIDTH=2 and WIDTH=8 instances, queue scoreboard on accepted words.
module tb_serial_bus_rx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_bus_rx_if #(.WIDTH(2)) if2();
  serial_bus_rx_if #(.WIDTH(8)) if8();

  serial_bus_rx #(.WIDTH(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
  serial_bus_rx #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(if8));

  int errors = 0;
  int checks = 0;
  int acc2 = 0;
  int acc8 = 0;
  logic [1:0] exp2[$];
  logic [7:0] exp8[$];
  logic [1:0] e2;
  logic [7:0] e8;

  // Scoreboards: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset === 1'b0 && if2.bus_valid === 1'b1 && if2.bus_ready === 1'b1) begin
      checks++;
      acc2++;
      if (exp2.size() == 0) begin
        errors++;
        $display("FAIL sb2_unexpected got=%h expected=none", if2.bus_out);
      end else begin
        e2 = exp2.pop_front();
        if (if2.bus_out !== e2) begin
          errors++;
          $display("FAIL sb2_data got=%h expected=%h", if2.bus_out, e2);
        end
      end
    end
    if (reset === 1'b0 && if8.bus_valid === 1'b1 && if8.bus_ready === 1'b1) begin
      checks++;
      acc8++;
      if (exp8.size() == 0) begin
        errors++;
        $display("FAIL sb8_unexpected got=%h expected=none", if8.bus_out);
      end else begin
        e8 = exp8.pop_front();
        if (if8.bus_out !== e8) begin
          errors++;
          $display("FAIL sb8_data got=%h expected=%h", if8.bus_out, e8);
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    if2.sframe = 1'b0; if2.sdata = 1'b0;
    if8.sframe = 1'b0; if8.sdata = 1'b0;
  endtask

  task automatic send2(input logic [1:0] w, input bit rdy_last);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if2.sframe = (i == 0);
      if2.sdata  = w[i];
`ifndef PARITY_CHECK_EN
      if (rdy_last && i == 1) if2.bus_ready = 1'b1;
`endif
    end
`ifdef PARITY_CHECK_EN
    @(posedge clk); #1;
    if2.sframe = 1'b0;
    if2.sdata  = ^w;
    if (rdy_last) if2.bus_ready = 1'b1;
`endif
  endtask

  task automatic send8(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      if8.sframe = (i == 0);
      if8.sdata  = w[i];
    end
`ifdef PARITY_CHECK_EN
    if (nbits == 8) begin
      @(posedge clk); #1;
      if8.sframe = 1'b0;
      if8.sdata  = ^w;
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if2.sdata = 0; if2.sframe = 0; if2.bus_ready = 0; if2.clr_err = 0;
    if8.sdata = 0; if8.sframe = 0; if8.bus_ready = 0; if8.clr_err = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if2.bus_valid, if2.overrun, if2.frame_err, if2.bus_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_w2 got=%b expected=00000", {if2.bus_valid, if2.overrun, if2.frame_err, if2.bus_out});
    end
    checks++;
    if ({if8.bus_valid, if8.overrun, if8.frame_err, if8.bus_out} !== 11'b0) begin
      errors++;
      $display("FAIL reset_w8 got=%b expected=0", {if8.bus_valid, if8.overrun, if8.frame_err, if8.bus_out});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    if2.bus_ready = 1'b1;
    exp2.push_back(2'b01);
    send2(2'b01, 1'b0);
    idle();
    @(negedge clk);
    checks++;
    if (if2.bus_valid !== 1'b1 || if2.bus_out !== 2'b01) begin
      errors++;
      $display("FAIL single_valid got=%b/%b expected=1/01", if2.bus_valid, if2.bus_out);
    end
    checks++;
    if (if2.overrun !== 1'b0 || if2.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL single_flags got=%b%b expected=00", if2.overrun, if2.frame_err);
    end
    @(negedge clk);
    checks++;
    if (if2.bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drop got=%b expected=0", if2.bus_valid);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = acc2;
    if2.bus_ready = 1'b1;
    exp2.push_back(2'b10); exp2.push_back(2'b11); exp2.push_back(2'b01);
    send2(2'b10, 1'b0);
    send2(2'b11, 1'b0);
    send2(2'b01, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (acc2 - a0 !== 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d expected=3", acc2 - a0);
    end
    checks++;
    if (if2.bus_valid !== 1'b0 || if2.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got=%b%b expected=00", if2.bus_valid, if2.frame_err);
    end
  endtask

  task automatic test_overrun();
    if2.bus_ready = 1'b0;
    exp2.push_back(2'b01);
    send2(2'b01, 1'b0);
    send2(2'b10, 1'b0);
    idle();
    @(negedge clk);
    checks++;
    if (if2.bus_valid !== 1'b1 || if2.bus_out !== 2'b01 || if2.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold got=%b/%b/%b expected=1/01/1", if2.bus_valid, if2.bus_out, if2.overrun);
    end
    @(posedge clk); #1;
    if2.bus_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if2.bus_valid !== 1'b0 || if2.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_accept got=%b/%b expected=0/1", if2.bus_valid, if2.overrun);
    end
    @(posedge clk); #1; if2.clr_err = 1'b1;
    @(posedge clk); #1; if2.clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (if2.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr got=%b expected=0", if2.overrun);
    end
  endtask

  task automatic test_accept_and_load();
    if2.bus_ready = 1'b0;
    exp2.push_back(2'b01); exp2.push_back(2'b11);
    send2(2'b01, 1'b0);
    idle();
    @(negedge clk);
    checks++;
    if (if2.bus_valid !== 1'b1 || if2.bus_out !== 2'b01) begin
      errors++;
      $display("FAIL al_first got=%b/%b expected=1/01", if2.bus_valid, if2.bus_out);
    end
    send2(2'b11, 1'b1);
    idle();
    if2.bus_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (if2.bus_valid !== 1'b1 || if2.bus_out !== 2'b11 || if2.overrun !== 1'b0) begin
      errors++;
      $display("FAIL al_load got=%b/%b/%b expected=1/11/0", if2.bus_valid, if2.bus_out, if2.overrun);
    end
    @(posedge clk); #1; if2.bus_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if2.bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL al_drain got=%b expected=0", if2.bus_valid);
    end
  endtask

  task automatic test_frame_err();
    if8.bus_ready = 1'b1;
    exp8.push_back(8'h3C);
    send8(8'hA5, 4);
    send8(8'h3C, 8);
    idle();
    @(negedge clk);
    checks++;
    if (if8.frame_err !== 1'b1 || if8.bus_valid !== 1'b1 || if8.bus_out !== 8'h3C) begin
      errors++;
      $display("FAIL ferr_word got=%b/%b/%h expected=1/1/3c", if8.frame_err, if8.bus_valid, if8.bus_out);
    end
    @(posedge clk); #1; if8.clr_err = 1'b1;
    @(posedge clk); #1; if8.clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (if8.frame_err !== 1'b0 || if8.bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL ferr_clr got=%b/%b expected=0/0", if8.frame_err, if8.bus_valid);
    end
  endtask

  task automatic test_async_reset();
    if8.bus_ready = 1'b0;
    send8(8'h55, 8);
    send8(8'h12, 3);
    send8(8'h34, 2);
    @(negedge clk);
    checks++;
    if (if8.bus_valid !== 1'b1 || if8.frame_err !== 1'b1 || if8.bus_out !== 8'h55) begin
      errors++;
      $display("FAIL ares_pre got=%b/%b/%h expected=1/1/55", if8.bus_valid, if8.frame_err, if8.bus_out);
    end
    reset = 1'b1;
    if8.sframe = 1'b0; if8.sdata = 1'b0;
    #1;
    checks++;
    if ({if8.bus_valid, if8.overrun, if8.frame_err, if8.bus_out} !== 11'b0) begin
      errors++;
      $display("FAIL ares_clear got=%b expected=0", {if8.bus_valid, if8.overrun, if8.frame_err, if8.bus_out});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    if8.bus_ready = 1'b1;
    exp8.push_back(8'hC3);
    send8(8'hC3, 8);
    idle();
    @(negedge clk);
    checks++;
    if (if8.bus_valid !== 1'b1 || if8.bus_out !== 8'hC3 || if8.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ares_after got=%b/%h/%b expected=1/c3/0", if8.bus_valid, if8.bus_out, if8.frame_err);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    int a0;
    logic [7:0] w;
    if8.bus_ready = 1'b1;
    exp8.push_back(8'h0F);
    send8(8'h0F, 8);
    idle();
    @(negedge clk);
    checks++;
    if (if8.bus_valid !== 1'b1 || if8.bus_out !== 8'h0F || if8.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL par_good got=%b/%h/%b expected=1/0f/0", if8.bus_valid, if8.bus_out, if8.parity_err);
    end
    @(negedge clk);
    a0 = acc8;
    w = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if8.sframe = (i == 0);
      if8.sdata  = w[i];
    end
    @(posedge clk); #1;
    if8.sframe = 1'b0;
    if8.sdata  = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (if8.parity_err !== 1'b1 || if8.bus_valid !== 1'b0 || acc8 != a0) begin
      errors++;
      $display("FAIL par_bad got=%b/%b/%0d expected=1/0/%0d", if8.parity_err, if8.bus_valid, acc8, a0);
    end
    @(posedge clk); #1; if8.clr_err = 1'b1;
    @(posedge clk); #1; if8.clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (if8.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL par_clr got=%b expected=0", if8.parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_accept_and_load();
    test_frame_err();
    test_async_reset();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp2.size() != 0) begin
      errors++;
      $display("FAIL sb2_leftover got=%0d expected=0", exp2.size());
    end
    checks++;
    if (exp8.size() != 0) begin
      errors++;
      $display("FAIL sb8_leftover got=%0d expected=0", exp8.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_bus_rx.md
Name: serial_bus_rx

Overview:
- Receive end of the two-wire serial bus link (sdata + sframe strobe) between fabric tiles; the transmit side drives frames LSB-first, and this block sits at the tile input.
- Reassembles each frame into a WIDTH-bit parallel word and presents it on a valid/ready output port.
- Flags overrun and framing errors as sticky status bits for the tile controller.

Parameters:
WIDTH, 2, data bits per frame (1..32)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
sdata  input  1  serial data, LSB first, sampled every clk
sframe  input  1  high on the cycle carrying bit 0 of a frame
bus_out  output  WIDTH  received word, stable while bus_valid=1
bus_valid  output  1  bus_out holds an unconsumed word
bus_ready  input  1  consumer accepts word when bus_valid&bus_ready
overrun  output  1  sticky: completed word dropped because output was full
frame_err  output  1  sticky: sframe seen before current frame completed
clr_err  input  1  synchronous clear of overrun and frame_err

Behaviour:
- Reset (async, any state): state=IDLE, bit counter=0, shift register=0, bus_out=0, bus_valid=0, overrun=0, frame_err=0.
- States IDLE, SHIFT (plus PARITY when feature enabled).
- IDLE: sdata ignored while sframe=0. When sframe=1: capture sdata as bit 0 and set count=1. Next state is SHIFT, or word-complete if WIDTH=1.
- SHIFT: each cycle capture sdata into bit[count] and increment count. The edge capturing bit WIDTH-1 completes the word; next state is IDLE.
- Back-to-back frames: sframe may rise on the cycle immediately after the last bit (zero gap). No idle cycle is required.
- sframe=1 while in SHIFT: abort the partial word, set frame_err, treat the current sdata as bit 0 of a new frame (count=1, stay in SHIFT).
- Word-complete latency: bus_out/bus_valid update on the same edge that samples the last bit, so they are visible the following cycle. A WIDTH-bit frame starting at edge 0 gives bus_valid=1 after edge WIDTH-1.
- Output register on word-complete:
  - bus_valid=0, or bus_valid&bus_ready in the same cycle: load the new word, bus_valid=1.
  - bus_valid=1 and bus_ready=0: drop the new word, bus_out unchanged, set overrun.
- Handshake: bus_valid falls on the edge where bus_valid&bus_ready=1 and no new word completes. bus_ready while bus_valid=0 has no effect. bus_out is never modified while bus_valid=1 except on a simultaneous accept+load.
- clr_err: clears both sticky flags. If clr_err and a new error event occur in the same cycle, the error wins (flag stays 1).
- Count width: clog2(WIDTH+1) bits. No wrap: the counter resets to 0 on completion or abort.

Optional Feature:
PARITY_CHECK_EN:
- Defined:
  - Each frame carries one extra even-parity bit after bit WIDTH-1. SHIFT goes to PARITY after the last data bit, and PARITY samples the parity bit.
  - Word-complete moves to the PARITY edge, so latency is +1 cycle.
  - XOR of data and parity = 1: drop the word and set new sticky output parity_err. parity_err is cleared by clr_err and reset to 0.
  - sframe=1 in PARITY: abort and restart exactly as in SHIFT, and set frame_err.
- Undefined: no PARITY state, no parity_err port, frame length is exactly WIDTH cycles.

Test Plan:
1. WIDTH=2, reset released, sframe=1/sdata=1 then sframe=0/sdata=0, bus_ready=1 -> bus_valid=1 one cycle after the second bit, with bus_out=2'b01; bus_valid drops the next cycle; no error flags.
2. WIDTH=2, frames 2'b10, 2'b11, 2'b01 back-to-back with zero gap, bus_ready=1 -> three consecutive single-cycle bus_valid pulses carrying 10, 11, 01.
3. WIDTH=2, bus_ready=0, two frames 2'b01 then 2'b10 -> bus_out stays 01 and overrun=1. Then raise bus_ready -> 01 accepted, bus_valid=0. Then clr_err -> overrun=0.
4. WIDTH=8, start frame 0xA5, assert sframe on bit 4 and send 0x3C from there -> frame_err=1, only 0x3C delivered. Async reset asserted mid-frame -> all outputs 0 immediately, next full frame received correctly.
5. WIDTH=2, bus_valid=1 holding 01, bus_ready=1 on the exact cycle frame 2'b11 completes -> 01 accepted, bus_out=11, bus_valid stays 1, overrun=0.
6. PARITY_CHECK_EN, WIDTH=8: frame 0x0F with parity 0 -> delivered. Frame 0x0F with parity 1 -> dropped, parity_err=1, bus_valid unchanged.
